// File: rtl/bf16_fma_sched.sv
// Two-requester round-robin scheduler for a shared pipelined bf16 FMA core.
// Issue is credit-gated so every returning result has a response slot.
module bf16_fma_sched #(
    parameter int LAT       = 3,
    parameter int RSP_DEPTH = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [47:0] req0_opnd,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [47:0] req1_opnd,
    output logic        fma_in_valid,
    output logic [47:0] fma_opnd,
    input  logic        fma_out_valid,
    input  logic [15:0] fma_result,
    input  logic [4:0]  fma_flags,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [20:0] rsp0_data,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [20:0] rsp1_data,
    output logic        busy,
    output logic        proto_err
);
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(RSP_DEPTH);
    localparam logic [PW-1:0] LAST    = PW'(RSP_DEPTH - 1);

    logic           rr_q, rr_d;
    logic [LAT-1:0] tag_v_q, tag_v_d;
    logic [LAT-1:0] tag_id_q, tag_id_d;
    logic           perr_q, perr_d;
    logic [CW-1:0]  infl_q [2];
    logic [CW-1:0]  infl_d [2];
    logic [CW-1:0]  cnt_q [2];
    logic [CW-1:0]  cnt_d [2];
    logic [PW-1:0]  wp_q [2];
    logic [PW-1:0]  wp_d [2];
    logic [PW-1:0]  rp_q [2];
    logic [PW-1:0]  rp_d [2];
    logic [20:0]    mem_q [2][RSP_DEPTH];
    logic [20:0]    mem_d [2][RSP_DEPTH];

    logic [1:0]     req_v, rsp_rdy, elig, gnt, push, pop, rsp_v, exit_hit;
    logic           exit_v, exit_id;
    logic [20:0]    rsp_d [2];

    always_comb begin
        req_v   = {req1_valid, req0_valid};
        rsp_rdy = {rsp1_ready, rsp0_ready};
        exit_v  = tag_v_q[LAT-1];
        exit_id = tag_id_q[LAT-1];
        for (int i = 0; i < 2; i++) begin
            elig[i]  = req_v[i] &
                       (({1'b0, infl_q[i]} + {1'b0, cnt_q[i]}) < DEPTH_W);
            rsp_v[i] = (cnt_q[i] != '0);
            rsp_d[i] = rsp_v[i] ? mem_q[i][rp_q[i]] : '0;
        end
        // Reset blocks grants so nothing issues into a pipe being cleared
        gnt[0] = ~wb_rst_i & elig[0] & (~elig[1] | ~rr_q);
        gnt[1] = ~wb_rst_i & elig[1] & (~elig[0] | rr_q);
        rr_d   = (|gnt) ? ~gnt[1] : rr_q;

        tag_v_d     = '0;
        tag_id_d    = '0;
        tag_v_d[0]  = |gnt;
        tag_id_d[0] = gnt[1];
        for (int k = 1; k < LAT; k++) begin
            tag_v_d[k]  = tag_v_q[k-1];
            tag_id_d[k] = tag_id_q[k-1];
        end

        perr_d = perr_q | (fma_out_valid ^ exit_v);
        mem_d  = mem_q;
        for (int i = 0; i < 2; i++) begin
            exit_hit[i] = exit_v & (exit_id == 1'(i));
            push[i]     = exit_hit[i] & fma_out_valid;
            pop[i]      = rsp_v[i] & rsp_rdy[i];
            infl_d[i]   = infl_q[i] + CW'(gnt[i]) - CW'(exit_hit[i]);
            cnt_d[i]    = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
            wp_d[i]     = wp_q[i];
            rp_d[i]     = rp_q[i];
            if (push[i]) begin
                mem_d[i][wp_q[i]] = {fma_flags, fma_result};
                wp_d[i] = (wp_q[i] == LAST) ? '0 : wp_q[i] + 1'b1;
            end
            if (pop[i]) begin
                rp_d[i] = (rp_q[i] == LAST) ? '0 : rp_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rr_q     <= 1'b0;
            tag_v_q  <= '0;
            tag_id_q <= '0;
            perr_q   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                infl_q[i] <= '0;
                cnt_q[i]  <= '0;
                wp_q[i]   <= '0;
                rp_q[i]   <= '0;
            end
        end else begin
            rr_q     <= rr_d;
            tag_v_q  <= tag_v_d;
            tag_id_q <= tag_id_d;
            perr_q   <= perr_d;
            for (int i = 0; i < 2; i++) begin
                infl_q[i] <= infl_d[i];
                cnt_q[i]  <= cnt_d[i];
                wp_q[i]   <= wp_d[i];
                rp_q[i]   <= rp_d[i];
            end
        end
    end

    // Storage needs no reset: data is masked while the count is zero
    always_ff @(posedge wb_clk_i) begin
        mem_q <= mem_d;
    end

    assign req0_ready   = gnt[0];
    assign req1_ready   = gnt[1];
    assign fma_in_valid = |gnt;
    assign fma_opnd     = gnt[1] ? req1_opnd : (gnt[0] ? req0_opnd : '0);
    assign rsp0_valid   = rsp_v[0];
    assign rsp1_valid   = rsp_v[1];
    assign rsp0_data    = rsp_d[0];
    assign rsp1_data    = rsp_d[1];
    assign busy         = (|tag_v_q) | (|rsp_v);
    assign proto_err    = perr_q;
endmodule

// File: tb/tb_bf16_fma_sched.sv
// Directed bench for bf16_fma_sched with an ideal fixed-latency core.
// Core stand-in returns hand-computed bf16 results for known vectors.
module tb_bf16_fma_sched;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [47:0] req0_opnd = '0, req1_opnd = '0;
    logic        fma_in_valid;
    logic [47:0] fma_opnd;
    logic        fma_out_valid;
    logic [15:0] fma_result;
    logic [4:0]  fma_flags;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [20:0] rsp0_data, rsp1_data;
    logic        busy, proto_err;

    int passed = 0;
    int total  = 0;

    logic [47:0] op0 [4] = '{48'h3F80_4000_3F80, 48'h4000_4000_0000,
                             48'h3F80_3F80_3F80, 48'h4040_4000_3F80};
    logic [20:0] res0 [4] = '{21'h04040, 21'h04080, 21'h04000, 21'h040E0};
    logic [47:0] op1 [4] = '{48'h7F80_0000_0000, 48'h4000_3F80_BF80,
                             48'h4000_4040_0000, 48'hBF80_4000_0000};
    logic [20:0] res1 [4] = '{21'h107FC0, 21'h03F80, 21'h040C0, 21'h0C000};

    logic [20:0] q0 [$];
    logic [20:0] q1 [$];

    bf16_fma_sched #(.LAT(LAT), .RSP_DEPTH(2)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opnd(req0_opnd),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opnd(req1_opnd),
        .fma_in_valid(fma_in_valid), .fma_opnd(fma_opnd),
        .fma_out_valid(fma_out_valid), .fma_result(fma_result),
        .fma_flags(fma_flags),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .busy(busy), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] core_fn(input logic [47:0] op);
        case (op)
            48'h3F80_4000_3F80: core_fn = 21'h04040;
            48'h4000_4000_0000: core_fn = 21'h04080;
            48'h3F80_3F80_3F80: core_fn = 21'h04000;
            48'h4040_4000_3F80: core_fn = 21'h040E0;
            48'h7F80_0000_0000: core_fn = 21'h107FC0;
            48'h4000_3F80_BF80: core_fn = 21'h03F80;
            48'h4000_4040_0000: core_fn = 21'h040C0;
            48'hBF80_4000_0000: core_fn = 21'h0C000;
            default:            core_fn = 21'h1FDEAD;
        endcase
    endfunction

    logic [LAT-1:0] cv;
    logic [47:0]    cop [LAT];
    logic           inj = 1'b0;
    logic [20:0]    core_out;

    always @(posedge clk) begin
        if (rst) cv <= '0;
        else     cv <= {cv[LAT-2:0], fma_in_valid};
        cop[0] <= fma_opnd;
        for (int k = 1; k < LAT; k++) cop[k] <= cop[k-1];
    end

    assign core_out      = core_fn(cop[LAT-1]);
    assign fma_out_valid = cv[LAT-1] | inj;
    assign fma_result    = core_out[15:0];
    assign fma_flags     = core_out[20:16];

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        req0_opnd = op0[0]; req1_opnd = op1[0];
        for (int k = 0; k < 2; k++) begin
            #1;
            total++;
            if ({req0_ready, req1_ready, fma_in_valid} !== 3'b000 || fma_opnd !== '0)
                $display("FAIL reset_grant: got %b opnd %h want 000 opnd 0",
                         {req0_ready, req1_ready, fma_in_valid}, fma_opnd);
            else passed++;
            cyc();
        end
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        total++;
        if ({rsp0_valid, rsp1_valid, busy, proto_err} !== 4'b0000 ||
            rsp0_data !== '0 || rsp1_data !== '0)
            $display("FAIL reset_state: got %b %h %h want 0000 0 0",
                     {rsp0_valid, rsp1_valid, busy, proto_err}, rsp0_data, rsp1_data);
        else passed++;
    endtask

    task automatic test_single();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_opnd = op0[0];
        #1;
        total++;
        if (req0_ready !== 1'b1 || fma_in_valid !== 1'b1 || fma_opnd !== op0[0])
            $display("FAIL single_issue: got rdy %b iv %b opnd %h want 1 1 %h",
                     req0_ready, fma_in_valid, fma_opnd, op0[0]);
        else passed++;
        cyc();
        req0_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            #1;
            total++;
            if (rsp0_valid !== 1'b0)
                $display("FAIL single_early: cycle %0d got %b want 0", k, rsp0_valid);
            else passed++;
            cyc();
        end
        #1;
        total++;
        if (rsp0_valid !== 1'b1 || rsp0_data !== 21'h04040 || busy !== 1'b1)
            $display("FAIL single_rsp: got v %b d %h busy %b want 1 04040 1",
                     rsp0_valid, rsp0_data, busy);
        else passed++;
        cyc();
        #1;
        total++;
        if (rsp0_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL single_drain: got v %b busy %b want 0 0", rsp0_valid, busy);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_g [10] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b00,
                                   2'b10, 2'b01, 2'b10, 2'b01, 2'b00};
        int i0 = 0, i1 = 0, n0 = 0, n1 = 0;
        q0.delete(); q1.delete();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            req0_valid = (i0 < 4); req0_opnd = op0[i0 & 3];
            req1_valid = (i1 < 4); req1_opnd = op1[i1 & 3];
            #1;
            if (rsp0_valid) begin
                total++;
                if (q0.size() == 0 || rsp0_data !== q0[0])
                    $display("FAIL b2b_rsp0: got %h want %h", rsp0_data,
                             (q0.size() != 0) ? q0[0] : 21'h0);
                else passed++;
                if (q0.size() != 0) void'(q0.pop_front());
                n0++;
            end
            if (rsp1_valid) begin
                total++;
                if (q1.size() == 0 || rsp1_data !== q1[0])
                    $display("FAIL b2b_rsp1: got %h want %h", rsp1_data,
                             (q1.size() != 0) ? q1[0] : 21'h0);
                else passed++;
                if (q1.size() != 0) void'(q1.pop_front());
                n1++;
            end
            if (k < 10) begin
                total++;
                if ({req1_ready, req0_ready} !== exp_g[k])
                    $display("FAIL b2b_grant: cycle %0d got %b want %b",
                             k, {req1_ready, req0_ready}, exp_g[k]);
                else passed++;
            end
            if (req0_ready) begin q0.push_back(res0[i0 & 3]); i0++; end
            if (req1_ready) begin q1.push_back(res1[i1 & 3]); i1++; end
            cyc();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        total++;
        if (n0 != 4 || n1 != 4 || busy !== 1'b0)
            $display("FAIL b2b_count: got %0d/%0d busy %b want 4/4 0", n0, n1, busy);
        else passed++;
    endtask

    task automatic test_backpressure();
        int a0 = 0, a1 = 0, n1 = 0;
        q1.delete();
        rsp0_ready = 1'b1; rsp1_ready = 1'b0;
        for (int k = 0; k < 12; k++) begin
            req0_valid = 1'b1; req0_opnd = op0[a0 & 3];
            req1_valid = 1'b1; req1_opnd = op1[a1 & 3];
            #1;
            if (req1_ready) begin q1.push_back(res1[a1 & 3]); a1++; end
            if (req0_ready) a0++;
            cyc();
        end
        #1;
        total++;
        if (a1 != 2 || a0 < 3 || req1_ready !== 1'b0 || rsp1_valid !== 1'b1)
            $display("FAIL bp_block: got a1 %0d a0 %0d rdy1 %b v1 %b want 2 >=3 0 1",
                     a1, a0, req1_ready, rsp1_valid);
        else passed++;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp1_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (rsp1_valid) begin
                total++;
                if (q1.size() == 0 || rsp1_data !== q1[0])
                    $display("FAIL bp_drain: got %h want %h", rsp1_data,
                             (q1.size() != 0) ? q1[0] : 21'h0);
                else passed++;
                if (q1.size() != 0) void'(q1.pop_front());
                n1++;
            end
            cyc();
        end
        total++;
        if (n1 != 2) $display("FAIL bp_drain_count: got %0d want 2", n1);
        else passed++;
        req1_valid = 1'b1; req1_opnd = op1[2];
        #1;
        total++;
        if (req1_ready !== 1'b1) $display("FAIL bp_resume: got %b want 1", req1_ready);
        else passed++;
        cyc();
        req1_valid = 1'b0;
        n1 = 0;
        for (int k = 0; k < 8 && n1 == 0; k++) begin
            #1;
            if (rsp1_valid) begin
                n1++;
                total++;
                if (rsp1_data !== 21'h040C0)
                    $display("FAIL bp_resume_rsp: got %h want 040c0", rsp1_data);
                else passed++;
            end
            cyc();
        end
        total++;
        if (n1 != 1) $display("FAIL bp_resume_timeout: got %0d rsps want 1", n1);
        else passed++;
        repeat (4) cyc();
    endtask

    task automatic test_reset_inflight();
        int seen = 0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_opnd = op0[1];
        req1_valid = 1'b1; req1_opnd = op1[1];
        cyc();
        cyc();
        rst = 1'b1;
        #1;
        total++;
        if ({req0_ready, req1_ready, fma_in_valid} !== 3'b000)
            $display("FAIL rst_flight_grant: got %b want 000",
                     {req0_ready, req1_ready, fma_in_valid});
        else passed++;
        cyc();
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        total++;
        if ({rsp0_valid, rsp1_valid, busy, proto_err, fma_in_valid} !== 5'b0 ||
            fma_opnd !== '0)
            $display("FAIL rst_flight_state: got %b opnd %h want 00000 0",
                     {rsp0_valid, rsp1_valid, busy, proto_err, fma_in_valid}, fma_opnd);
        else passed++;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (rsp0_valid || rsp1_valid || busy || proto_err) seen++;
            cyc();
        end
        total++;
        if (seen != 0) $display("FAIL rst_flight_ghost: got %0d active cycles want 0", seen);
        else passed++;
    endtask

    task automatic test_inject();
        int n = 0;
        inj = 1'b1;
        cyc();
        inj = 1'b0;
        #1;
        total++;
        if (proto_err !== 1'b1 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0)
            $display("FAIL inject_set: got err %b v %b%b want 1 00",
                     proto_err, rsp0_valid, rsp1_valid);
        else passed++;
        repeat (3) cyc();
        req1_valid = 1'b1; req1_opnd = op0[0];
        #1;
        total++;
        if (proto_err !== 1'b1 || req1_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL inject_hold: got err %b rdy %b busy %b want 1 1 0",
                     proto_err, req1_ready, busy);
        else passed++;
        cyc();
        req1_valid = 1'b0;
        for (int k = 0; k < 8 && n == 0; k++) begin
            #1;
            if (rsp1_valid) begin
                n++;
                total++;
                if (rsp1_data !== 21'h04040 || proto_err !== 1'b1)
                    $display("FAIL inject_after: got %h err %b want 04040 1",
                             rsp1_data, proto_err);
                else passed++;
            end
            cyc();
        end
        total++;
        if (n != 1) $display("FAIL inject_timeout: got %0d rsps want 1", n);
        else passed++;
    endtask

    task automatic test_push_pop();
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_opnd = op0[2];
        #1;
        total++;
        if (req0_ready !== 1'b1) $display("FAIL pp_issue_a: got %b want 1", req0_ready);
        else passed++;
        cyc();
        req0_opnd = op0[3];
        #1;
        total++;
        if (req0_ready !== 1'b1) $display("FAIL pp_issue_b: got %b want 1", req0_ready);
        else passed++;
        cyc();
        req0_valid = 1'b0;
        cyc();
        cyc();
        #1;
        total++;
        if (rsp0_valid !== 1'b1 || rsp0_data !== 21'h04000)
            $display("FAIL pp_first: got %b %h want 1 04000", rsp0_valid, rsp0_data);
        else passed++;
        rsp0_ready = 1'b1;
        cyc();
        rsp0_ready = 1'b0;
        #1;
        total++;
        if (rsp0_valid !== 1'b1 || rsp0_data !== 21'h040E0)
            $display("FAIL pp_second: got %b %h want 1 040e0", rsp0_valid, rsp0_data);
        else passed++;
        cyc();
        #1;
        total++;
        if (rsp0_valid !== 1'b1 || rsp0_data !== 21'h040E0)
            $display("FAIL pp_hold: got %b %h want 1 040e0", rsp0_valid, rsp0_data);
        else passed++;
        rsp0_ready = 1'b1;
        cyc();
        #1;
        total++;
        if (rsp0_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL pp_count: got v %b busy %b want 0 0", rsp0_valid, busy);
        else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_inflight();
        test_inject();
        test_push_pop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
